// File: rtl/apollo_chip_sequencer.sv
// ---------------------------------------------------------------------------
// apollo_chip_sequencer
// Turns one accelerator command (form/prog, read_mem, read_reg, inference)
// into a timed pin sequence (SETUP -> PULSE -> HOLD) for the Apollo
// memristor-array chip, then returns the synchronised chip data as a
// one-cycle response.
//
// Ports
//   clk_sys_in, rst_sys_in          : clock, synchronous active-high reset
//   cmd_valid_i / cmd_ready_o       : command handshake (ready == IDLE)
//   cmd_op_i, cmd_col_i, cmd_row_i  : opcode and array address
//   cmd_wdata_i                     : program polarity (1 = set)
//   cfg_pulse_cyc_i                 : strobe width in cycles, 0 acts as 1
//   rsp_valid_o, rsp_data_o         : completion pulse and captured bits
//   busy_o                          : sequencer not idle
//   CBL, CBLEN, CSL, CWL            : registered chip strobes
//   instructions, addr_col, addr_row: registered chip code / address
//   bit_out                         : asynchronous chip data
// ---------------------------------------------------------------------------
module apollo_chip_sequencer #(
  parameter int unsigned SETUP_CYC = 4,
  parameter int unsigned HOLD_CYC  = 4,
  parameter int unsigned NBITS     = 4
) (
  input  logic             clk_sys_in,
  input  logic             rst_sys_in,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_op_i,
  input  logic [4:0]       cmd_col_i,
  input  logic [4:0]       cmd_row_i,
  input  logic             cmd_wdata_i,
  input  logic [7:0]       cfg_pulse_cyc_i,
  output logic             rsp_valid_o,
  output logic [NBITS-1:0] rsp_data_o,
  output logic             busy_o,
  output logic             CBL,
  output logic             CBLEN,
  output logic             CSL,
  output logic             CWL,
  output logic [1:0]       instructions,
  output logic [4:0]       addr_col,
  output logic [4:0]       addr_row,
  input  logic [NBITS-1:0] bit_out
);

  localparam int unsigned CNT_W = 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_PULSE = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam logic [1:0] OP_PROG     = 2'b11;
  localparam logic [1:0] OP_READ_REG = 2'b01;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_pulse;
  logic             r_wdata;
  logic [1:0]       r_instr;
  logic [4:0]       r_col;
  logic [4:0]       r_row;
  logic             r_cbl, r_cblen, r_csl, r_cwl;
  logic             r_rsp_valid;
  logic [NBITS-1:0] r_rsp_data;
  logic [NBITS-1:0] r_sync1, r_sync2;

  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_accept;
  logic [1:0]       w_op_nxt;
  logic             w_wdata_nxt;
  logic [CNT_W-1:0] w_pulse_cfg;
  logic             w_active, w_in_pulse;
  logic             w_cbl_nxt, w_cblen_nxt, w_csl_nxt, w_cwl_nxt;
  logic             w_rsp_valid_nxt;
  logic [NBITS-1:0] w_rsp_data_nxt;

  // Next-state, counter, response and pin-level logic
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_data_nxt  = r_rsp_data;
    w_accept        = (r_state == S_IDLE) && cmd_valid_i;
    w_pulse_cfg     = (cfg_pulse_cyc_i == 8'd0) ? 8'd1 : cfg_pulse_cyc_i;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_SETUP;
          w_cnt_nxt   = CNT_W'(SETUP_CYC - 1);
        end
      end
      S_SETUP: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_PULSE;
          w_cnt_nxt   = r_pulse - 8'd1;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      S_PULSE: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = CNT_W'(HOLD_CYC - 1);
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      default: begin
        if (r_cnt == '0) begin
          w_state_nxt     = S_IDLE;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_data_nxt  = (r_instr == OP_PROG) ? '0 : r_sync2;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
    endcase

    // Pins are registered, so decode them from the state/op of the next cycle
    w_op_nxt    = w_accept ? cmd_op_i    : r_instr;
    w_wdata_nxt = w_accept ? cmd_wdata_i : r_wdata;
    w_active    = (w_state_nxt != S_IDLE);
    w_in_pulse  = (w_state_nxt == S_PULSE);
    w_cbl_nxt   = 1'b0;
    w_cblen_nxt = 1'b0;
    w_csl_nxt   = 1'b0;
    w_cwl_nxt   = 1'b0;
    case (w_op_nxt)
      OP_PROG: begin
        w_cblen_nxt = w_active;
        w_cbl_nxt   = w_active & w_wdata_nxt;
        w_csl_nxt   = w_active & ~w_wdata_nxt;
        w_cwl_nxt   = w_in_pulse;
      end
      OP_READ_REG: begin
        w_cwl_nxt = 1'b0;
      end
      default: begin
        w_csl_nxt = w_in_pulse;
        w_cwl_nxt = w_in_pulse;
      end
    endcase
  end

  // State, command latches, pins and data synchroniser
  always_ff @(posedge clk_sys_in) begin
    if (rst_sys_in) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_pulse     <= '0;
      r_wdata     <= 1'b0;
      r_instr     <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_cbl       <= 1'b0;
      r_cblen     <= 1'b0;
      r_csl       <= 1'b0;
      r_cwl       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_sync1     <= '0;
      r_sync2     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cbl       <= w_cbl_nxt;
      r_cblen     <= w_cblen_nxt;
      r_csl       <= w_csl_nxt;
      r_cwl       <= w_cwl_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_sync1     <= bit_out;
      r_sync2     <= r_sync1;
      if (w_accept) begin
        r_pulse <= w_pulse_cfg;
        r_wdata <= cmd_wdata_i;
        r_instr <= cmd_op_i;
        r_col   <= cmd_col_i;
        r_row   <= cmd_row_i;
      end
    end
  end

  assign cmd_ready_o  = (r_state == S_IDLE);
  assign busy_o       = ~cmd_ready_o;
  assign rsp_valid_o  = r_rsp_valid;
  assign rsp_data_o   = r_rsp_data;
  assign CBL          = r_cbl;
  assign CBLEN        = r_cblen;
  assign CSL          = r_csl;
  assign CWL          = r_cwl;
  assign instructions = r_instr;
  assign addr_col     = r_col;
  assign addr_row     = r_row;

endmodule

// File: tb/tb_apollo_chip_sequencer.sv
// ---------------------------------------------------------------------------
// tb_apollo_chip_sequencer
// Directed bench for apollo_chip_sequencer with default parameters
// (S = 4, H = 4). Expected pin windows are written per cycle relative to
// the accept cycle T; outputs are sampled 1 time unit after each edge.
// ---------------------------------------------------------------------------
module tb_apollo_chip_sequencer;

  logic       clk_sys_in;
  logic       rst_sys_in;
  logic       cmd_valid_i;
  logic       cmd_ready_o;
  logic [1:0] cmd_op_i;
  logic [4:0] cmd_col_i;
  logic [4:0] cmd_row_i;
  logic       cmd_wdata_i;
  logic [7:0] cfg_pulse_cyc_i;
  logic       rsp_valid_o;
  logic [3:0] rsp_data_o;
  logic       busy_o;
  logic       CBL, CBLEN, CSL, CWL;
  logic [1:0] instructions;
  logic [4:0] addr_col;
  logic [4:0] addr_row;
  logic [3:0] bit_out;

  int n_checks;
  int n_fail;

  apollo_chip_sequencer dut (
    .clk_sys_in      (clk_sys_in),
    .rst_sys_in      (rst_sys_in),
    .cmd_valid_i     (cmd_valid_i),
    .cmd_ready_o     (cmd_ready_o),
    .cmd_op_i        (cmd_op_i),
    .cmd_col_i       (cmd_col_i),
    .cmd_row_i       (cmd_row_i),
    .cmd_wdata_i     (cmd_wdata_i),
    .cfg_pulse_cyc_i (cfg_pulse_cyc_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_data_o      (rsp_data_o),
    .busy_o          (busy_o),
    .CBL             (CBL),
    .CBLEN           (CBLEN),
    .CSL             (CSL),
    .CWL             (CWL),
    .instructions    (instructions),
    .addr_col        (addr_col),
    .addr_row        (addr_row),
    .bit_out         (bit_out)
  );

  initial clk_sys_in = 1'b0;
  always #5 clk_sys_in = ~clk_sys_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys_in);
    #1;
  endtask

  // Present a command in the current (ready) cycle T; returns in T+1
  task automatic issue(input logic [1:0] op, input logic [4:0] col, input logic [4:0] row,
                       input logic wd, input logic [7:0] pw);
    cmd_op_i        = op;
    cmd_col_i       = col;
    cmd_row_i       = row;
    cmd_wdata_i     = wd;
    cfg_pulse_cyc_i = pw;
    cmd_valid_i     = 1'b1;
    tick();
    cmd_valid_i     = 1'b0;
  endtask

  task automatic check_strobes(input string tag, input logic cbl, input logic cblen,
                               input logic csl, input logic cwl);
    check({tag, ".CBL"},   32'(CBL),   32'(cbl));
    check({tag, ".CBLEN"}, 32'(CBLEN), 32'(cblen));
    check({tag, ".CSL"},   32'(CSL),   32'(csl));
    check({tag, ".CWL"},   32'(CWL),   32'(cwl));
  endtask

  int n_acc;
  int n_rsp;

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    rst_sys_in      = 1'b1;
    cmd_valid_i     = 1'b0;
    cmd_op_i        = 2'b00;
    cmd_col_i       = 5'd0;
    cmd_row_i       = 5'd0;
    cmd_wdata_i     = 1'b0;
    cfg_pulse_cyc_i = 8'd8;
    bit_out         = 4'b0000;

    // Reset state
    tick();
    tick();
    check_strobes("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst.ready", 32'(cmd_ready_o), 32'd1);
    check("rst.busy",  32'(busy_o),      32'd0);
    check("rst.rspv",  32'(rsp_valid_o), 32'd0);
    check("rst.rspd",  32'(rsp_data_o),  32'd0);
    check("rst.instr", 32'(instructions), 32'd0);
    check("rst.col",   32'(addr_col),    32'd0);
    rst_sys_in = 1'b0;
    tick();

    // Program, set polarity, P = 8: response at T+17
    bit_out = 4'b1010;
    issue(2'b11, 5'd3, 5'd17, 1'b1, 8'd8);
    for (int k = 1; k <= 17; k++) begin
      check("prog.col",   32'(addr_col),     32'd3);
      check("prog.row",   32'(addr_row),     32'd17);
      check("prog.instr", 32'(instructions), 32'd3);
      check_strobes("prog", k <= 16, k <= 16, 1'b0, (k >= 5) && (k <= 12));
      check("prog.busy",  32'(busy_o),       32'(k <= 16));
      check("prog.rspv",  32'(rsp_valid_o),  32'(k == 17));
      if (k == 17) begin
        check("prog.rspd",  32'(rsp_data_o),  32'd0);
        check("prog.ready", 32'(cmd_ready_o), 32'd1);
      end else begin
        tick();
      end
    end

    // read_mem, P = 3: strobes T+5..T+7, response at T+12
    issue(2'b10, 5'd7, 5'd9, 1'b0, 8'd3);
    for (int k = 1; k <= 12; k++) begin
      check("rdm.instr", 32'(instructions), 32'd2);
      check_strobes("rdm", 1'b0, 1'b0, (k >= 5) && (k <= 7), (k >= 5) && (k <= 7));
      check("rdm.rspv",  32'(rsp_valid_o),  32'(k == 12));
      if (k == 12) check("rdm.rspd", 32'(rsp_data_o), 32'hA);
      else tick();
    end

    // read_reg, P = 2 (response T+11), then inference issued in that cycle
    issue(2'b01, 5'd1, 5'd2, 1'b0, 8'd2);
    for (int k = 1; k <= 11; k++) begin
      check_strobes("rdr", 1'b0, 1'b0, 1'b0, 1'b0);
      check("rdr.rspv", 32'(rsp_valid_o), 32'(k == 11));
      if (k == 11) check("rdr.rspd", 32'(rsp_data_o), 32'hA);
      else tick();
    end
    bit_out = 4'b0101;
    issue(2'b00, 5'd4, 5'd5, 1'b0, 8'd1);
    for (int k = 1; k <= 10; k++) begin
      check("inf.instr", 32'(instructions), 32'd0);
      check("inf.col",   32'(addr_col),     32'd4);
      check_strobes("inf", 1'b0, 1'b0, k == 5, k == 5);
      check("inf.rspv",  32'(rsp_valid_o),  32'(k == 10));
      if (k == 10) check("inf.rspd", 32'(rsp_data_o), 32'h5);
      else tick();
    end

    // Pulse width 0 behaves as 1; a mid-command cfg change is ignored
    issue(2'b10, 5'd0, 5'd0, 1'b0, 8'd0);
    cfg_pulse_cyc_i = 8'd200;
    for (int k = 1; k <= 10; k++) begin
      check_strobes("pw0", 1'b0, 1'b0, k == 5, k == 5);
      check("pw0.rspv", 32'(rsp_valid_o), 32'(k == 10));
      if (k < 10) tick();
    end

    // Reset during the PULSE of a reset-polarity program
    issue(2'b11, 5'd10, 5'd20, 1'b0, 8'd8);
    for (int k = 1; k < 6; k++) tick();
    check_strobes("abort.pre", 1'b0, 1'b1, 1'b1, 1'b1);
    rst_sys_in = 1'b1;
    tick();
    rst_sys_in = 1'b0;
    check_strobes("abort", 1'b0, 1'b0, 1'b0, 1'b0);
    check("abort.ready", 32'(cmd_ready_o),  32'd1);
    check("abort.instr", 32'(instructions), 32'd0);
    check("abort.col",   32'(addr_col),     32'd0);
    check("abort.row",   32'(addr_row),     32'd0);
    n_rsp = 0;
    for (int k = 0; k < 20; k++) begin
      if (rsp_valid_o) n_rsp++;
      tick();
    end
    check("abort.norsp", 32'(n_rsp), 32'd0);
    issue(2'b01, 5'd2, 5'd3, 1'b0, 8'd1);
    for (int k = 1; k <= 10; k++) begin
      check("post.rspv", 32'(rsp_valid_o), 32'(k == 10));
      if (k == 10) check("post.rspd", 32'(rsp_data_o), 32'h5);
      else tick();
    end

    // cmd_valid held high: one accept per completion, 10-cycle cadence
    cmd_op_i        = 2'b01;
    cfg_pulse_cyc_i = 8'd1;
    cmd_valid_i     = 1'b1;
    n_acc = 0;
    n_rsp = 0;
    for (int c = 0; c < 35; c++) begin
      if (cmd_ready_o) n_acc++;
      if (rsp_valid_o && c != 0) n_rsp++;
      tick();
    end
    cmd_valid_i = 1'b0;
    for (int c = 35; c < 50; c++) begin
      if (cmd_ready_o && cmd_valid_i) n_acc++;
      if (rsp_valid_o) n_rsp++;
      tick();
    end
    check("hold.accepts", 32'(n_acc), 32'd4);
    check("hold.rsps",    32'(n_rsp), 32'd4);
    check("hold.idle",    32'(busy_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apollo_chip_sequencer.md
Name: apollo_chip_sequencer

Overview:
- Converts single accelerator commands (form/program, read_mem, read_reg, inference) into timed pin sequences for the external Apollo memristor-array chip.
- Drives the CBL/CBLEN/CSL/CWL strobes, the 2-bit instruction code and the 5-bit column/row addresses.
- Synchronises and captures the chip's 4 DATA_out bits and returns them as a one-cycle response.
- Sits inside pinaipple_system, between the bus-facing accelerator register block (upstream) and the chip pins (downstream).

Parameters:
SETUP_CYC, 4, cycles addresses/instruction are stable before the strobe pulse (1..255)
HOLD_CYC, 4, cycles after the pulse before completion (2..255)
NBITS, 4, width of chip data output

Ports:
clk_sys_in  input  1  system clock
rst_sys_in  input  1  synchronous active-high reset
cmd_valid_i  input  1  command request
cmd_ready_o  output  1  sequencer can accept a command
cmd_op_i  input  2  11 form/prog, 10 read_mem, 01 read_reg, 00 inference
cmd_col_i  input  5  column address
cmd_row_i  input  5  row address
cmd_wdata_i  input  1  program polarity (1 = set, 0 = reset)
cfg_pulse_cyc_i  input  8  strobe pulse width in cycles; 0 is treated as 1
rsp_valid_o  output  1  one-cycle completion pulse
rsp_data_o  output  NBITS  captured chip bits; 0 for form/prog
busy_o  output  1  high when state != IDLE
CBL  output  1  bit-line drive level
CBLEN  output  1  bit-line enable
CSL  output  1  source-line strobe
CWL  output  1  word-line strobe
instructions  output  2  chip instruction code
addr_col  output  5  chip column address
addr_row  output  5  chip row address
bit_out  input  NBITS  asynchronous chip data, synchronised internally

Behaviour:
- Clock and reset: one clock. rst_sys_in is synchronous and active-high.
- Reset values: every output 0, state IDLE, rsp_data_o 0, synchroniser flops 0.
- All chip-facing outputs are registered. No combinational path from any input to any pin.
- States: IDLE -> SETUP -> PULSE -> HOLD -> IDLE.
- Handshake:
  - cmd_ready_o = (state == IDLE).
  - A command is accepted when cmd_valid_i and cmd_ready_o are both high in cycle T.
  - At accept, latch op, col, row, wdata and pulse width (max(cfg_pulse_cyc_i, 1)).
  - instructions, addr_col and addr_row take the latched values from T+1. They hold until the next accept, including through IDLE.
- Timing, with S = SETUP_CYC, P = latched pulse width, H = HOLD_CYC:
  - SETUP occupies T+1 .. T+S.
  - PULSE occupies T+S+1 .. T+S+P.
  - HOLD occupies the next H cycles.
  - rsp_valid_o is high for exactly cycle T+S+P+H+1, with state already IDLE. cmd_ready_o is high in that same cycle, so back-to-back commands are allowed.
  - Default latency with P = 8: accept T, response T+17.
- A single down-counter of 8 bits is loaded at each state entry.
- Pin levels per op:
  - form/prog: CBLEN = 1 in SETUP, PULSE and HOLD. CBL = wdata and CSL = ~wdata in the same window. CWL = 1 in PULSE only.
  - read_mem and inference: CBLEN = 0, CBL = 0. CSL = 1 and CWL = 1 in PULSE only.
  - read_reg: all four strobes stay 0. Only instructions and addresses change.
  - In IDLE all four strobes are 0.
- Data capture:
  - bit_out passes through a 2-flop synchroniser.
  - For every op except form/prog, rsp_data_o loads the synchronised value on the last HOLD cycle. HOLD_CYC >= 2 guarantees the pulse-time value has propagated.
  - For form/prog, rsp_data_o loads 0.
  - rsp_data_o holds between responses.
- cmd_valid_i while busy: ignored and not queued. The upstream block must hold it until cmd_ready_o is high.
- Reset mid-operation: on the next edge, state is IDLE, all strobes are 0, and instructions and addresses are 0. No rsp_valid_o is issued for the aborted command.
- cfg_pulse_cyc_i changes after accept have no effect on the running command.
- busy_o = ~cmd_ready_o.

Test Plan:
- Program: op=11, col=5'd3, row=5'd17, wdata=1, pulse=8 accepted at T -> addr_col=3 and addr_row=17 from T+1; CBLEN and CBL high T+1..T+16; CSL low; CWL high exactly T+5..T+12; rsp_valid at T+17 with rsp_data=0.
- read_mem: bit_out held at 4'b1010, op=10, pulse=3 -> CSL and CWL high T+5..T+7; CBLEN=0; rsp_valid at T+12 with rsp_data=4'b1010.
- read_reg plus back-to-back: inference issued in the rsp_valid cycle of a read_reg -> both accepted, no strobes during read_reg, second rsp exactly S+P+H+1 cycles after the second accept.
- cfg_pulse_cyc=0 -> PULSE lasts 1 cycle; changing cfg_pulse_cyc_i mid-command does not alter the width.
- Reset asserted during PULSE of a program -> next cycle all strobes 0, cmd_ready high, no rsp_valid; a new command then completes normally.
- cmd_valid held high while busy -> exactly one accept per completion; no commands are dropped or duplicated.
